// File: rtl/cpu_div_pkg.sv
// Shared definitions for the iterative radix-2 divider: FSM encoding and default widths.
`timescale 1ns/1ps
package cpu_div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/cpu_div_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fix-up.
`timescale 1ns/1ps
module cpu_div_negate #(
  parameter int DATA_W = 32
) (
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] y
);

  assign y = en ? (~a + {{(DATA_W-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/cpu_div_cell.sv
// Iterative 32-bit restoring divider: one quotient bit per cycle, fixed latency,
// truncating signed/unsigned division with divide-by-zero reporting.
`timescale 1ns/1ps
module cpu_div_cell
  import cpu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_quot,
  output logic [DATA_W-1:0] M_div_rem,
  output logic              M_div_dbz
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int MSB   = DATA_W - 1;

  div_state_e        state_q, state_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic              signed_q, signed_d;
  logic              quot_neg_q, quot_neg_d, rem_neg_q, rem_neg_d;
  logic              dbz_q, dbz_d;
  logic [DATA_W-1:0] prem_q, prem_d;   // partial remainder
  logic [DATA_W-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quot_q, quot_d, rem_q, rem_d;
  logic              dbz_out_q, dbz_out_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              fix_phase;
  logic [DATA_W-1:0] neg_a_in, neg_a_out, neg_b_in, neg_b_out;
  logic              neg_a_en, neg_b_en;
  logic [DATA_W:0]   shifted, trial;

  // The two negators are shared: operand magnitudes in PREP, sign correction in FIX.
  always_comb begin
    fix_phase = (state_q == FIX);
    neg_a_in  = fix_phase ? dvd_q      : src1_q;
    neg_a_en  = fix_phase ? quot_neg_q : (signed_q & src1_q[MSB]);
    neg_b_in  = fix_phase ? prem_q     : src2_q;
    neg_b_en  = fix_phase ? rem_neg_q  : (signed_q & src2_q[MSB]);
  end

  cpu_div_negate #(.DATA_W(DATA_W)) u_neg_a (.en(neg_a_en), .a(neg_a_in), .y(neg_a_out));
  cpu_div_negate #(.DATA_W(DATA_W)) u_neg_b (.en(neg_b_en), .a(neg_b_in), .y(neg_b_out));

  // Partial remainder stays below the divisor, so the DATA_W+1-bit difference never wraps.
  assign shifted = {prem_q, dvd_q[MSB]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d    = state_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    signed_d   = signed_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    dbz_d      = dbz_q;
    prem_d     = prem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_out_d  = dbz_out_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (E_div_start) begin
          src1_d   = E_src1;
          src2_d   = E_src2;
          signed_d = E_div_signed;
          state_d  = PREP;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      PREP: begin
        dvd_d      = neg_a_out;
        dvs_d      = neg_b_out;
        quot_neg_d = signed_q & (src1_q[MSB] ^ src2_q[MSB]);
        rem_neg_d  = signed_q & src1_q[MSB];
        dbz_d      = (src2_q == '0);
        prem_d     = '0;
        cnt_d      = CNT_W'(DATA_W - 1);
        state_d    = ITER;
      end
      ITER: begin
        prem_d = trial[DATA_W] ? shifted[MSB:0] : trial[MSB:0];
        dvd_d  = {dvd_q[MSB-1:0], ~trial[DATA_W]};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        // Divide-by-zero reports the raw dividend as remainder, without sign fix-up.
        quot_d    = dbz_q ? '1     : neg_a_out;
        rem_d     = dbz_q ? src1_q : neg_b_out;
        dbz_out_d = dbz_q;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PREP) || (state_d == ITER) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      signed_q   <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_q      <= 1'b0;
      prem_q     <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      signed_q   <= signed_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      dbz_q      <= dbz_d;
      prem_q     <= prem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_out_q  <= dbz_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign M_div_busy = busy_q;
  assign M_div_done = done_q;
  assign M_div_quot = quot_q;
  assign M_div_rem  = rem_q;
  assign M_div_dbz  = dbz_out_q;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Directed-vector bench for cpu_div_cell: results, latency, busy window, ignored start,
// back-to-back issue and mid-operation reset.
`timescale 1ns/1ps
module tb_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_src1, E_src2;
  logic        E_div_start, E_div_signed;
  logic        M_div_busy, M_div_done, M_div_dbz;
  logic [31:0] M_div_quot, M_div_rem;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cpu_div_cell #(.DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .E_src1       (E_src1),
    .E_src2       (E_src2),
    .E_div_start  (E_div_start),
    .E_div_signed (E_div_signed),
    .M_div_busy   (M_div_busy),
    .M_div_done   (M_div_done),
    .M_div_quot   (M_div_quot),
    .M_div_rem    (M_div_rem),
    .M_div_dbz    (M_div_dbz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    else             n_pass++;
  endtask

  // Called at a negedge; the following posedge samples the start request.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sg);
    E_src1       = a;
    E_src2       = b;
    E_div_signed = sg;
    E_div_start  = 1'b1;
    @(posedge clk);
    #1 E_div_start = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the start edge; returns at the negedge of the done cycle.
  task automatic wait_done(input int inj, input logic [31:0] ia, input logic [31:0] ib,
                           output int lat, output int busy_err);
    lat      = -1;
    busy_err = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      E_div_start = 1'b0;
      if (M_div_done) begin
        lat = cyc;
        if (M_div_busy) busy_err++;
        break;
      end
      if (!M_div_busy) busy_err++;
      if (cyc == inj) begin
        E_src1      = ia;
        E_src2      = ib;
        E_div_start = 1'b1;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input bit no_sync, input bit tail, input int inj);
    int lat, busy_err;
    if (!no_sync) @(negedge clk);
    launch(a, b, sg);
    wait_done(inj, 32'd77, 32'd3, lat, busy_err);
    check({tag, "_latency"}, 32'(lat), 32'd35);
    check({tag, "_busy"}, 32'(busy_err), 32'd0);
    check({tag, "_quot"}, M_div_quot, eq);
    check({tag, "_rem"}, M_div_rem, er);
    check({tag, "_dbz"}, {31'd0, M_div_dbz}, {31'd0, edbz});
    if (tail) begin
      @(negedge clk);
      check({tag, "_done_width"}, {31'd0, M_div_done}, 32'd0);
      check({tag, "_hold_quot"}, M_div_quot, eq);
    end
  endtask

  initial begin
    int dones;
    reset        = 1'b1;
    E_src1       = '0;
    E_src2       = '0;
    E_div_start  = 1'b0;
    E_div_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, M_div_busy}, 32'd0);
    check("rst_done", {31'd0, M_div_done}, 32'd0);
    check("rst_quot", M_div_quot, 32'd0);
    check("rst_rem", M_div_rem, 32'd0);
    check("rst_dbz", {31'd0, M_div_dbz}, 32'd0);
    reset = 1'b0;

    run_op("u100_7",   32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 0, 1, 0);
    run_op("sm100_7",  32'hFFFF_FF9C, 32'd7,         1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 0, 1, 0);
    run_op("s100_m7",  32'd100,       32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2,         1'b0, 0, 1, 0);
    run_op("s5_0",     32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF, 32'd5,         1'b1, 0, 1, 0);
    run_op("u5_0",     32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         1'b1, 0, 1, 0);
    run_op("sm5_0",    32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0, 1, 0);
    run_op("s_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, 0, 1, 0);
    run_op("u_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0, 0, 1, 0);
    run_op("ign_start", 32'd1000,     32'd10,        1'b0, 32'd100,       32'd0,         1'b0, 0, 0, 10);
    run_op("b2b",      32'hFFFF_FFFF, 32'h10,        1'b0, 32'h0FFF_FFFF, 32'hF,         1'b0, 1, 1, 0);

    // Mid-operation reset discards the in-flight divide.
    @(negedge clk);
    launch(32'd50, 32'd3, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {31'd0, M_div_busy}, 32'd0);
    check("midrst_done", {31'd0, M_div_done}, 32'd0);
    check("midrst_quot", M_div_quot, 32'd0);
    check("midrst_rem", M_div_rem, 32'd0);
    check("midrst_dbz", {31'd0, M_div_dbz}, 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (M_div_done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_op("after_rst", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
